// File: rtl/switch_debounce_sync.sv
// Slide-switch front end: 2-flop synchroniser, per-bit debounce,
// rise/fall pulses and the two packed input-port words.
module switch_debounce_sync #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_changed,
    output logic [31:0]     in_word0,
    output logic [31:0]     in_word1
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sync1_q;
    logic [N_SW-1:0]  sync2_q;
    logic [N_SW-1:0]  stable_q;
    logic [N_SW-1:0]  stable_d;
    logic [N_SW-1:0]  rise_q;
    logic [N_SW-1:0]  rise_d;
    logic [N_SW-1:0]  fall_q;
    logic [N_SW-1:0]  fall_d;
    logic             changed_q;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];

    // Counter only runs while the synchronised level disagrees with
    // the accepted one; any agreement discards the partial count.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable  = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
    assign in_word0   = {27'd0, stable_q[9:5]};
    assign in_word1   = {27'd0, stable_q[4:0]};

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: directed scenarios plus random
// stimulus against a sliding-window reference model.
module tb_switch_debounce_sync;

    localparam int DC = 4;
    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] sw_raw;
    logic [NS-1:0] sw_stable;
    logic [NS-1:0] sw_rise;
    logic [NS-1:0] sw_fall;
    logic          sw_changed;
    logic [31:0]   in_word0;
    logic [31:0]   in_word1;

    switch_debounce_sync #(
        .N_SW(NS),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed),
        .in_word0(in_word0),
        .in_word1(in_word1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Edge-indexed history of what the DUT sampled.
    logic [NS-1:0] raw_h[$];
    bit            rst_h[$];

    logic [NS-1:0] m_stable = '0;
    logic [NS-1:0] m_rise   = '0;
    logic [NS-1:0] m_fall   = '0;

    int rise_cnt[NS];
    int fall_cnt[NS];
    int rise_edge[NS];
    int chg_cycles;
    int edge_n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     tag, got, exp, edge_n);
        end
    endtask

    function automatic bit rst_at(int x);
        if (x < 0) return 1'b1;
        return rst_h[x];
    endfunction

    // Level on the second synchroniser flop just before edge m.
    function automatic bit s_at(int m, int i);
        if (rst_at(m - 1) || rst_at(m - 2)) return 1'b0;
        return raw_h[m - 2][i];
    endfunction

    // A bit flips at edge n when the DC most recent synchronised
    // samples, all taken out of reset, disagree with the held level.
    task automatic model_edge(input int n);
        logic [NS-1:0] acc;
        acc = '0;
        if (rst_at(n)) begin
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (rst_at(n - j)) ok = 1'b0;
                else if (s_at(n - j, i) == m_stable[i]) ok = 1'b0;
            end
            acc[i] = ok;
        end
        m_rise   = acc & ~m_stable;
        m_fall   = acc & m_stable;
        m_stable = m_stable ^ acc;
    endtask

    task automatic step(input logic [NS-1:0] raw, input logic rst);
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        raw_h.push_back(raw);
        rst_h.push_back(rst);
        edge_n = raw_h.size() - 1;
        model_edge(edge_n);
        #1;
        chk("stable", 32'(sw_stable), 32'(m_stable));
        chk("rise", 32'(sw_rise), 32'(m_rise));
        chk("fall", 32'(sw_fall), 32'(m_fall));
        chk("changed", 32'(sw_changed), 32'(|(m_rise | m_fall)));
        chk("word0", in_word0, {27'd0, m_stable[9:5]});
        chk("word1", in_word1, {27'd0, m_stable[4:0]});
        for (int i = 0; i < NS; i++) begin
            if (sw_rise[i] === 1'b1) begin
                rise_cnt[i]++;
                rise_edge[i] = edge_n;
            end
            if (sw_fall[i] === 1'b1) fall_cnt[i]++;
        end
        if (sw_changed === 1'b1) chg_cycles++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NS; i++) begin
            rise_cnt[i]  = 0;
            fall_cnt[i]  = 0;
            rise_edge[i] = -1;
        end
        chg_cycles = 0;
    endtask

    task automatic hold(input logic [NS-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    initial begin
        int k0;
        logic [NS-1:0] r;
        sw_raw = '0;
        reset  = 1'b1;
        edge_n = 0;
        clr_counts();

        // Reset with all switches low.
        step('0, 1'b1);
        chk("rst_w0", in_word0, 32'h0);
        chk("rst_w1", in_word1, 32'h0);
        step('0, 1'b1);
        hold('0, 20);
        chk("idle_chg", 32'(chg_cycles), 32'd0);

        // Clean step on bit 0.
        clr_counts();
        k0 = raw_h.size();
        hold(10'h001, 8);
        chk("clean_rise_n", 32'(rise_cnt[0]), 32'd1);
        chk("clean_rise_t", 32'(rise_edge[0] - k0), 32'd5);
        chk("clean_w1", in_word1, 32'h1);
        hold('0, 8);
        chk("clean_fall_n", 32'(fall_cnt[0]), 32'd1);
        chk("clean_chg", 32'(chg_cycles), 32'd2);

        // Short glitch on bit 3 is rejected; one of DC cycles is not.
        clr_counts();
        hold(10'h008, 3);
        hold('0, 10);
        chk("glitch3_rise", 32'(rise_cnt[3]), 32'd0);
        hold(10'h008, 4);
        hold('0, 12);
        chk("glitch4_rise", 32'(rise_cnt[3]), 32'd1);
        chk("glitch4_fall", 32'(fall_cnt[3]), 32'd1);

        // Bounce on bit 9.
        clr_counts();
        step(10'h200, 1'b0);
        step(10'h000, 1'b0);
        step(10'h200, 1'b0);
        step(10'h000, 1'b0);
        k0 = raw_h.size();
        hold(10'h200, 10);
        chk("bounce_rise_n", 32'(rise_cnt[9]), 32'd1);
        chk("bounce_rise_t", 32'(rise_edge[9] - k0), 32'd5);
        chk("bounce_w0", in_word0, 32'h10);
        hold('0, 10);

        // Start-up with every switch high.
        clr_counts();
        step(10'h3FF, 1'b1);
        step(10'h3FF, 1'b1);
        k0 = raw_h.size();
        hold(10'h3FF, 10);
        for (int i = 0; i < NS; i++) begin
            chk("start_rise_n", 32'(rise_cnt[i]), 32'd1);
            chk("start_rise_t", 32'(rise_edge[i] - k0), 32'd5);
        end
        chk("start_w0", in_word0, 32'h1F);
        chk("start_w1", in_word1, 32'h1F);

        // Reset while bit 5 is mid-count.
        step('0, 1'b1);
        hold('0, 6);
        clr_counts();
        hold(10'h020, 4);
        step(10'h020, 1'b1);
        k0 = raw_h.size();
        hold(10'h020, 10);
        chk("midrst_rise_n", 32'(rise_cnt[5]), 32'd1);
        chk("midrst_rise_t", 32'(rise_edge[5] - k0), 32'd5);

        // Random switch activity with occasional resets.
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 6) == 0) r[i] = ~r[i];
            end
            step(r, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
